// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU between the decode stage and register-file writeback.
//
// Operand side and result side both use valid/ready. A beat transfers on a
// rising clock edge where valid and ready are both high; the producer holds
// its payload stable while valid is high and ready is low, and valid never
// drops before the transfer completes.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready operand beat handshake
//   a, b, op          operands and opcode (ADD SUB AND OR XOR SHL SHR MUL)
//   out_valid/out_ready result beat handshake
//   y                 result
//   flag_z/n/c/v      zero, negative, carry/borrow/shift-out/MUL-high, signed overflow
//   err               illegal opcode (MUL with the multiplier compiled out)
//
// Optional feature: define ALU_MUL_EN to build the iterative shift-add
// multiplier (op 111, WIDTH+1 cycles in BUSY). Without it op 111 returns a
// single-cycle error result and no BUSY state exists.
//
// The FSM state is kept in the signal `state` for checkers to bind to.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, BUSY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

    state_t state, state_nxt;
    logic   accept;
    logic   is_mul;

    // Gated by rst_n so the producer sees no ready while reset is held.
    assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);

`ifdef ALU_MUL_EN
    assign is_mul = (op == OP_MUL);
`else
    assign is_mul = 1'b0;
`endif

    // Single-cycle result, computed from the live operands and captured on accept.
    logic [WIDTH-1:0] c_y;
    logic             c_c, c_v, c_err;
    logic [WIDTH:0]   sum, diff, shl_w, shr_w;
    logic [SHW-1:0]   amt;

    always_comb begin
        amt   = b[SHW-1:0];
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        // The extra bit catches the last bit shifted out; amount 0 leaves it 0.
        shl_w = {1'b0, a} << amt;
        shr_w = {a, 1'b0} >> amt;
        c_y   = '0;
        c_c   = 1'b0;
        c_v   = 1'b0;
        c_err = 1'b0;
        case (op)
            OP_ADD: begin
                c_y = sum[WIDTH-1:0];
                c_c = sum[WIDTH];
                c_v = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                c_y = diff[WIDTH-1:0];
                c_c = diff[WIDTH];  // borrow: a < b unsigned
                c_v = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: c_y = a & b;
            OP_OR:  c_y = a | b;
            OP_XOR: c_y = a ^ b;
            OP_SHL: begin
                c_y = shl_w[WIDTH-1:0];
                c_c = shl_w[WIDTH];
            end
            OP_SHR: begin
                c_y = shr_w[WIDTH:1];
                c_c = shr_w[0];
            end
            default: begin
`ifndef ALU_MUL_EN
                c_err = 1'b1;
`endif
            end
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [SHW:0] MUL_STEPS = (SHW + 1)'(WIDTH);
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW:0]       cnt;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    state_nxt = is_mul ? BUSY : DONE;
`else
                    state_nxt = DONE;
`endif
                end else if ((state == DONE) && out_ready) begin
                    state_nxt = IDLE;
                end
            end
`ifdef ALU_MUL_EN
            // WIDTH partial-product cycles, then one cycle to publish the result.
            BUSY: if (cnt == MUL_STEPS) state_nxt = DONE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            y      <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            err    <= 1'b0;
`ifdef ALU_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (accept && !is_mul) begin
                y      <= c_y;
                flag_z <= (c_y == '0);
                flag_n <= c_y[WIDTH-1];
                flag_c <= c_c;
                flag_v <= c_v;
                err    <= c_err;
            end
`ifdef ALU_MUL_EN
            if (accept && is_mul) begin
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                cnt    <= '0;
            end else if (state == BUSY) begin
                if (cnt == MUL_STEPS) begin
                    y      <= acc[WIDTH-1:0];
                    flag_z <= (acc[WIDTH-1:0] == '0);
                    flag_n <= acc[WIDTH-1];
                    flag_c <= (acc[2*WIDTH-1:WIDTH] != '0);
                    flag_v <= 1'b0;
                    err    <= 1'b0;
                end else begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
            end
`endif
        end
    end
endmodule
